key_mode_ctrl: RTL and testbench
================================

Name: key_mode_ctrl

Overview:
Upstream control stage for the LED flasher. It synchronises and debounces a raw active-low push-button and emits a single-cycle press event. Each debounced press advances a 4-state mode register. The mode is decoded into registered controls consumed by the flasher:
- flash enable
- half-period count
- steady-on force

Parameters:
T20MS, 20'd999_999, debounce window minus one in CLK cycles (20 ms at 50 MHz); the bench overrides it to 9
HALF_SLOW, 24'd12_499_999, flasher half-period count for SLOW mode (250 ms at 50 MHz)
HALF_FAST, 24'd2_499_999, flasher half-period count for FAST mode (50 ms at 50 MHz)

Ports:
CLK  input  1  system clock, 50 MHz
RST_N  input  1  asynchronous, active-low reset
KEY_IN  input  1  raw push-button, active-low, asynchronous to CLK, bouncy
KEY_PRESS  output  1  one-cycle pulse per debounced press
MODE  output  2  current mode: 0 OFF, 1 SLOW, 2 FAST, 3 ON
FLASH_EN  output  1  flasher counting enable
HALF_PERIOD  output  24  flasher terminal count
LED_FORCE  output  1  LED steady-on request; the flasher output is ORed with it downstream

Behaviour:
- Reset (asynchronous, RST_N low):
  - sync flops, stable state = 1 (released)
  - debounce counter = 0
  - MODE = 0, KEY_PRESS = 0, FLASH_EN = 0, LED_FORCE = 0, HALF_PERIOD = HALF_FAST
- Synchroniser: two flops s1 then s2 on KEY_IN. No other logic reads KEY_IN.
- Debounce, evaluated each edge:
  - if s2 == stable: cnt <= 0
  - else if cnt == T20MS: stable <= s2, cnt <= 0
  - else: cnt <= cnt + 1
- Debounce consequence: a level must differ from stable for T20MS+1 consecutive cycles to be accepted. Any bounce shorter than that restarts the count and is ignored.
- Press event: on the edge where stable transitions 1->0, KEY_PRESS is registered high for exactly one cycle.
  - A 0->1 transition (release) produces no event.
  - A key held low produces exactly one event; there is no auto-repeat.
- Latency: take edge 1 as the first edge that samples KEY_IN low, with KEY_IN held low throughout.
  - stable falls, KEY_PRESS rises and MODE updates all on edge T20MS+3.
  - With T20MS = 9, that is edge 12.
- Mode FSM: on a press, OFF -> SLOW -> FAST -> ON -> OFF. 2-bit wrap; no other transitions.
- Output decode: registered, updated on the same edge as MODE and computed from the next mode.
  - OFF: FLASH_EN 0, LED_FORCE 0, HALF_PERIOD HALF_FAST
  - SLOW: FLASH_EN 1, LED_FORCE 0, HALF_PERIOD HALF_SLOW
  - FAST: FLASH_EN 1, LED_FORCE 0, HALF_PERIOD HALF_FAST
  - ON: FLASH_EN 0, LED_FORCE 1, HALF_PERIOD HALF_FAST
- Outputs never glitch. HALF_PERIOD changes only on a mode change.
- Width rules: cnt is 20 bits and compares only against T20MS; it cannot overflow because it clears at T20MS. HALF_PERIOD is 24 bits and holds the parameter value unmodified.
- Reset mid-operation: all state returns to reset values immediately, including a partially accumulated count. If KEY_IN is still low after RST_N deasserts, the key is treated as a fresh press: one KEY_PRESS after T20MS+3 edges, MODE becomes SLOW.
- Glitch during count: a single-cycle high on s2 while counting toward a press clears cnt. The full window restarts from the next low sample.

Decomposition:
- Package key_mode_pkg holds:
  - mode encodings MODE_OFF = 2'd0, MODE_SLOW = 2'd1, MODE_FAST = 2'd2, MODE_ON = 2'd3
  - default T20MS / HALF_SLOW / HALF_FAST values
  - the width constants 20 and 24
- Sub-module key_debounce contains the synchroniser, debounce counter, stable register and press-pulse generation. It exposes CLK, RST_N, KEY_IN, KEY_STABLE and KEY_PRESS, parameterised by T20MS.
- The top level holds the mode FSM and output decode.

Test Plan:
1. Reset with KEY_IN = 1 -> MODE = 0, FLASH_EN = 0, LED_FORCE = 0, HALF_PERIOD = 2_499_999, KEY_PRESS = 0; the values hold for 100 cycles.
2. T20MS = 9, KEY_IN low for 50 cycles then high -> KEY_PRESS high only in the cycle after edge 12; MODE = 1, FLASH_EN = 1, HALF_PERIOD = 12_499_999; release produces no pulse.
3. Bounce: low 5 cycles, high 3, low 5, high 3, then high for 40 -> no KEY_PRESS, MODE stays 0.
4. Four clean presses (low 20 / high 20 each) -> MODE sequence 1, 2, 3, 0.
   - In mode 3: LED_FORCE = 1, FLASH_EN = 0, HALF_PERIOD = 2_499_999.
   - After the wrap: all outputs equal their reset values.
5. KEY_IN held low for 1000 cycles -> exactly one KEY_PRESS.
6. Mode at FAST, KEY_IN low for 6 cycles, RST_N pulsed low for 2 cycles with the key still low -> outputs reset asynchronously. The key stays low: one KEY_PRESS occurs 12 edges after reset release, and MODE = 1.

Source files
------------

// File: rtl/key_mode_pkg.sv
// Shared constants and mode encoding for the key-driven LED mode controller.
package key_mode_pkg;

  localparam int CNT_W  = 20;
  localparam int HALF_W = 24;

  // Defaults assume a 50 MHz CLK.
  localparam logic [CNT_W-1:0]  T20MS_DEF     = 20'd999_999;
  localparam logic [HALF_W-1:0] HALF_SLOW_DEF = 24'd12_499_999;
  localparam logic [HALF_W-1:0] HALF_FAST_DEF = 24'd2_499_999;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_SLOW = 2'd1,
    MODE_FAST = 2'd2,
    MODE_ON   = 2'd3
  } mode_t;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and debouncer for an active-low push-button.
// KEY_PRESS is a combinational strobe that is high during the cycle whose
// closing edge accepts a new low level. The parent registers it, so that the
// pulse, the accepted level and any state depending on it all change on the
// same edge.
module key_debounce
  import key_mode_pkg::*;
#(
  parameter logic [CNT_W-1:0] T20MS = T20MS_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic KEY_IN,
  output logic KEY_STABLE,
  output logic KEY_PRESS
);

  logic             s1;
  logic             s2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous key into the CLK domain; idle level is released (1).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= KEY_IN;
      s2 <= s1;
    end
  end

  // A new level is accepted only after T20MS+1 consecutive differing samples;
  // any sample that matches the stable level restarts the window.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stable <= 1'b1;
      cnt    <= '0;
    end else if (s2 == stable) begin
      cnt <= '0;
    end else if (cnt == T20MS) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign KEY_STABLE = stable;
  assign KEY_PRESS  = stable & ~s2 & (cnt == T20MS);

endmodule

// File: rtl/key_mode_ctrl.sv
// Key-driven mode controller for the LED flasher: each debounced press
// steps OFF -> SLOW -> FAST -> ON -> OFF, and the mode is decoded into
// registered flasher controls that change only when the mode changes.
module key_mode_ctrl
  import key_mode_pkg::*;
#(
  parameter logic [CNT_W-1:0]  T20MS     = T20MS_DEF,
  parameter logic [HALF_W-1:0] HALF_SLOW = HALF_SLOW_DEF,
  parameter logic [HALF_W-1:0] HALF_FAST = HALF_FAST_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              KEY_IN,
  output logic              KEY_PRESS,
  output logic [1:0]        MODE,
  output logic              FLASH_EN,
  output logic [HALF_W-1:0] HALF_PERIOD,
  output logic              LED_FORCE
);

  logic  key_stable;
  logic  press_strobe;
  logic  press_evt;
  mode_t mode_q;

  key_debounce #(
    .T20MS (T20MS)
  ) u_debounce (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .KEY_IN     (KEY_IN),
    .KEY_STABLE (key_stable),
    .KEY_PRESS  (press_strobe)
  );

  // A press can only be accepted while the key is still seen as released;
  // this keeps a stray strobe from ever firing on the release side.
  assign press_evt = press_strobe & key_stable;

  // Mode FSM with registered decode: outputs are loaded from the next mode
  // on the same edge the mode advances, so they never glitch.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q      <= MODE_OFF;
      KEY_PRESS   <= 1'b0;
      FLASH_EN    <= 1'b0;
      LED_FORCE   <= 1'b0;
      HALF_PERIOD <= HALF_FAST;
    end else begin
      KEY_PRESS <= press_evt;
      if (press_evt) begin
        case (mode_q)
          MODE_OFF: begin
            mode_q      <= MODE_SLOW;
            FLASH_EN    <= 1'b1;
            LED_FORCE   <= 1'b0;
            HALF_PERIOD <= HALF_SLOW;
          end
          MODE_SLOW: begin
            mode_q      <= MODE_FAST;
            FLASH_EN    <= 1'b1;
            LED_FORCE   <= 1'b0;
            HALF_PERIOD <= HALF_FAST;
          end
          MODE_FAST: begin
            mode_q      <= MODE_ON;
            FLASH_EN    <= 1'b0;
            LED_FORCE   <= 1'b1;
            HALF_PERIOD <= HALF_FAST;
          end
          default: begin
            mode_q      <= MODE_OFF;
            FLASH_EN    <= 1'b0;
            LED_FORCE   <= 1'b0;
            HALF_PERIOD <= HALF_FAST;
          end
        endcase
      end
    end
  end

  // The FSM state itself is the visible mode.
  assign MODE = mode_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed testbench for key_mode_ctrl with a short debounce window.
module tb_key_mode_ctrl;

  localparam logic [19:0] T20MS     = 20'd9;
  localparam logic [23:0] HALF_SLOW = 24'd12_499_999;
  localparam logic [23:0] HALF_FAST = 24'd2_499_999;

  logic        CLK;
  logic        RST_N;
  logic        KEY_IN;
  logic        KEY_PRESS;
  logic [1:0]  MODE;
  logic        FLASH_EN;
  logic [23:0] HALF_PERIOD;
  logic        LED_FORCE;

  int errors;
  int checks;
  int pulses;
  int edge_no;
  int last_pulse_edge;

  key_mode_ctrl #(
    .T20MS     (T20MS),
    .HALF_SLOW (HALF_SLOW),
    .HALF_FAST (HALF_FAST)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .KEY_IN      (KEY_IN),
    .KEY_PRESS   (KEY_PRESS),
    .MODE        (MODE),
    .FLASH_EN    (FLASH_EN),
    .HALF_PERIOD (HALF_PERIOD),
    .LED_FORCE   (LED_FORCE)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  // Driver: reset with the key released, leaving the bench at a negedge.
  task automatic do_reset();
    @(negedge CLK);
    KEY_IN = 1'b1;
    RST_N  = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    pulses          = 0;
    edge_no         = 0;
    last_pulse_edge = -1;
  endtask

  // Driver: hold KEY_IN at level for n edges, sampling after each edge.
  task automatic drive_key(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      KEY_IN = level;
      @(posedge CLK);
      @(negedge CLK);
      edge_no++;
      if (KEY_PRESS === 1'b1) begin
        pulses++;
        last_pulse_edge = edge_no;
      end
    end
  endtask

  task automatic test_reset();
    KEY_IN = 1'b1;
    RST_N  = 1'b0;
    #15;
    checks++;
    if ({MODE, FLASH_EN, LED_FORCE, KEY_PRESS, HALF_PERIOD} !== {2'd0, 1'b0, 1'b0, 1'b0, HALF_FAST}) begin
      errors++;
      $display("FAIL reset_values: mode=%0d fe=%0b lf=%0b kp=%0b half=%0d, want 0 0 0 0 %0d",
               MODE, FLASH_EN, LED_FORCE, KEY_PRESS, HALF_PERIOD, HALF_FAST);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      checks++;
      if ({MODE, FLASH_EN, LED_FORCE, KEY_PRESS, HALF_PERIOD} !== {2'd0, 1'b0, 1'b0, 1'b0, HALF_FAST}) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: mode=%0d fe=%0b lf=%0b kp=%0b half=%0d, want 0 0 0 0 %0d",
                 i, MODE, FLASH_EN, LED_FORCE, KEY_PRESS, HALF_PERIOD, HALF_FAST);
      end
    end
  endtask

  task automatic test_single_press();
    do_reset();
    drive_key(1'b0, 11);
    checks++;
    if (KEY_PRESS !== 1'b0 || MODE !== 2'd0) begin
      errors++;
      $display("FAIL press_edge11: kp=%0b mode=%0d, want 0 0", KEY_PRESS, MODE);
    end
    drive_key(1'b0, 1);
    checks++;
    if ({KEY_PRESS, MODE, FLASH_EN, LED_FORCE, HALF_PERIOD} !== {1'b1, 2'd1, 1'b1, 1'b0, HALF_SLOW}) begin
      errors++;
      $display("FAIL press_edge12: kp=%0b mode=%0d fe=%0b lf=%0b half=%0d, want 1 1 1 0 %0d",
               KEY_PRESS, MODE, FLASH_EN, LED_FORCE, HALF_PERIOD, HALF_SLOW);
    end
    drive_key(1'b0, 1);
    checks++;
    if (KEY_PRESS !== 1'b0) begin
      errors++;
      $display("FAIL press_edge13: kp=%0b, want 0", KEY_PRESS);
    end
    drive_key(1'b0, 37);
    drive_key(1'b1, 30);
    checks++;
    if (pulses !== 1 || last_pulse_edge !== 12 || MODE !== 2'd1) begin
      errors++;
      $display("FAIL press_release: pulses=%0d at edge %0d mode=%0d, want 1 at 12 mode 1",
               pulses, last_pulse_edge, MODE);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    drive_key(1'b0, 5);
    drive_key(1'b1, 3);
    drive_key(1'b0, 5);
    drive_key(1'b1, 3);
    drive_key(1'b1, 40);
    checks++;
    if (pulses !== 0 || MODE !== 2'd0) begin
      errors++;
      $display("FAIL bounce: pulses=%0d mode=%0d, want 0 0", pulses, MODE);
    end
  endtask

  task automatic test_mode_cycle();
    logic [1:0] exp_mode [4];
    exp_mode[0] = 2'd1;
    exp_mode[1] = 2'd2;
    exp_mode[2] = 2'd3;
    exp_mode[3] = 2'd0;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      drive_key(1'b0, 20);
      drive_key(1'b1, 20);
      checks++;
      if (MODE !== exp_mode[p] || pulses !== p + 1) begin
        errors++;
        $display("FAIL mode_cycle press %0d: mode=%0d pulses=%0d, want %0d %0d",
                 p, MODE, pulses, exp_mode[p], p + 1);
      end
      if (p == 1) begin
        checks++;
        if ({FLASH_EN, LED_FORCE, HALF_PERIOD} !== {1'b1, 1'b0, HALF_FAST}) begin
          errors++;
          $display("FAIL mode_fast: fe=%0b lf=%0b half=%0d, want 1 0 %0d",
                   FLASH_EN, LED_FORCE, HALF_PERIOD, HALF_FAST);
        end
      end
      if (p == 2) begin
        checks++;
        if ({FLASH_EN, LED_FORCE, HALF_PERIOD} !== {1'b0, 1'b1, HALF_FAST}) begin
          errors++;
          $display("FAIL mode_on: fe=%0b lf=%0b half=%0d, want 0 1 %0d",
                   FLASH_EN, LED_FORCE, HALF_PERIOD, HALF_FAST);
        end
      end
    end
    checks++;
    if ({KEY_PRESS, FLASH_EN, LED_FORCE, HALF_PERIOD} !== {1'b0, 1'b0, 1'b0, HALF_FAST}) begin
      errors++;
      $display("FAIL mode_wrap: kp=%0b fe=%0b lf=%0b half=%0d, want 0 0 0 %0d",
               KEY_PRESS, FLASH_EN, LED_FORCE, HALF_PERIOD, HALF_FAST);
    end
  endtask

  task automatic test_hold_no_repeat();
    do_reset();
    drive_key(1'b0, 1000);
    drive_key(1'b1, 20);
    checks++;
    if (pulses !== 1 || last_pulse_edge !== 12 || MODE !== 2'd1) begin
      errors++;
      $display("FAIL hold: pulses=%0d at edge %0d mode=%0d, want 1 at 12 mode 1",
               pulses, last_pulse_edge, MODE);
    end
  endtask

  task automatic test_reset_mid_press();
    do_reset();
    drive_key(1'b0, 20);
    drive_key(1'b1, 20);
    drive_key(1'b0, 20);
    drive_key(1'b1, 20);
    checks++;
    if (MODE !== 2'd2) begin
      errors++;
      $display("FAIL midrst_setup: mode=%0d, want 2", MODE);
    end
    drive_key(1'b0, 6);
    RST_N = 1'b0;
    #1;
    checks++;
    if ({MODE, FLASH_EN, LED_FORCE, KEY_PRESS, HALF_PERIOD} !== {2'd0, 1'b0, 1'b0, 1'b0, HALF_FAST}) begin
      errors++;
      $display("FAIL midrst_async: mode=%0d fe=%0b lf=%0b kp=%0b half=%0d, want 0 0 0 0 %0d",
               MODE, FLASH_EN, LED_FORCE, KEY_PRESS, HALF_PERIOD, HALF_FAST);
    end
    repeat (2) @(negedge CLK);
    RST_N           = 1'b1;
    pulses          = 0;
    edge_no         = 0;
    last_pulse_edge = -1;
    drive_key(1'b0, 12);
    checks++;
    if (KEY_PRESS !== 1'b1 || MODE !== 2'd1 || last_pulse_edge !== 12) begin
      errors++;
      $display("FAIL midrst_repress: kp=%0b mode=%0d edge=%0d, want 1 1 12",
               KEY_PRESS, MODE, last_pulse_edge);
    end
    drive_key(1'b0, 10);
    drive_key(1'b1, 20);
    checks++;
    if (pulses !== 1 || MODE !== 2'd1) begin
      errors++;
      $display("FAIL midrst_single: pulses=%0d mode=%0d, want 1 1", pulses, MODE);
    end
  endtask

  // Sequence and final report
  initial begin
    errors          = 0;
    checks          = 0;
    pulses          = 0;
    edge_no         = 0;
    last_pulse_edge = -1;
    KEY_IN          = 1'b1;
    RST_N           = 1'b1;
    test_reset();
    test_single_press();
    test_bounce();
    test_mode_cycle();
    test_hold_no_repeat();
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
